// File: rtl/fifo_ptr_pkg.sv
// Shared helpers for async-FIFO pointer handling: Gray conversion, synchroniser
// depth limits and sticky error-bit positions.
package fifo_ptr_pkg;

  localparam int unsigned STAGES_MIN = 2;
  localparam int unsigned STAGES_MAX = 4;

  localparam int unsigned ERR_JUMP = 0;
  localparam int unsigned ERR_OVF  = 1;

  // Widest pointer supported (ADDR_W up to 15 plus wrap bit); callers zero-extend.
  localparam int unsigned PTR_MAX_W = 16;

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_chain_n.sv
// Bare N-flop synchroniser chain with synchronous active-high reset.
// Shared by the read-side and write-side pointer receivers.
module sync_chain_n #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ptr_sync_rd_gen.sv
// Read-domain receiver for an async-FIFO write pointer: synchronise, decode,
// derive occupancy flags and flag integrity problems.
module ptr_sync_rd_gen
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDR_W:0]   wptr,
  input  logic [ADDR_W:0]   rptr_bin,
  input  logic              err_clr,
  output logic [ADDR_W:0]   rq_wptr_gray,
  output logic [ADDR_W:0]   rq_wptr_bin,
  output logic [ADDR_W:0]   rd_count,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic              wptr_upd,
  output logic [1:0]        sync_err
);

  localparam int unsigned PW = ADDR_W + 1;
  localparam logic [PW-1:0] FullCount = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PW-1:0] AeLevel   = PW'(AE_LEVEL);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $fatal(1, "ptr_sync_rd_gen: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end

  logic [PW-1:0] gray_s;
  logic [PW-1:0] gprev_q;
  logic [PW-1:0] bin_q;
  logic          upd_q;
  logic [1:0]    err_q;
  logic [1:0]    err_set;

  sync_chain_n #(
    .WIDTH  (PW),
    .STAGES (STAGES)
  ) u_chain (
    .clk (rclk),
    .rst (rrst),
    .d   (wptr),
    .q   (gray_s)
  );

  // Occupancy is purely local: registered decode against the read pointer.
  assign rd_count      = bin_q - rptr_bin;
  assign rempty        = (rd_count == '0);
  assign ralmost_empty = (rd_count <= AeLevel);

  always_comb begin
    err_set           = '0;
    err_set[ERR_JUMP] = ($countones(gray_s ^ gprev_q) > 1);
    err_set[ERR_OVF]  = (rd_count > FullCount);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      gprev_q <= '0;
      bin_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      bin_q   <= PW'(gray2bin(PTR_MAX_W'(gray_s)));
      gprev_q <= gray_s;
      upd_q   <= (gray_s != gprev_q);
      // A fresh error in the clear cycle survives.
      err_q   <= err_set | (err_q & {2{~err_clr}});
    end
  end

  assign rq_wptr_gray = gray_s;
  assign rq_wptr_bin  = bin_q;
  assign wptr_upd     = upd_q;
  assign sync_err     = err_q;

endmodule

// File: tb/tb_ptr_sync_rd_gen.sv
// Bench for ptr_sync_rd_gen: three instances (STAGES 2/3/4) share stimulus and
// are compared every cycle against a sample-history model, plus literal checks.
module tb_ptr_sync_rd_gen;
  import fifo_ptr_pkg::*;

  localparam int unsigned AW = 3;

  logic       clk = 1'b0;
  logic       rrst = 1'b1;
  logic [3:0] wptr = '0;
  logic [3:0] rptr_bin = '0;
  logic       err_clr = 1'b0;

  logic [3:0] d_gray [2:4];
  logic [3:0] d_bin  [2:4];
  logic [3:0] d_cnt  [2:4];
  logic       d_empty [2:4];
  logic       d_ae   [2:4];
  logic       d_upd  [2:4];
  logic [1:0] d_err  [2:4];

  int checks = 0;
  int errors = 0;
  int upd_pulses = 0;

  always #5 clk = ~clk;

  for (genvar g = 2; g <= 4; g++) begin : g_dut
    ptr_sync_rd_gen #(
      .ADDR_W   (AW),
      .STAGES   (g),
      .AE_LEVEL (2)
    ) u_dut (
      .rclk          (clk),
      .rrst          (rrst),
      .wptr          (wptr),
      .rptr_bin      (rptr_bin),
      .err_clr       (err_clr),
      .rq_wptr_gray  (d_gray[g]),
      .rq_wptr_bin   (d_bin[g]),
      .rd_count      (d_cnt[g]),
      .rempty        (d_empty[g]),
      .ralmost_empty (d_ae[g]),
      .wptr_upd      (d_upd[g]),
      .sync_err      (d_err[g])
    );
  end

  // Model: hist[k] is the wptr value sampled k+1 edges ago (zeros after reset).
  logic [3:0] hist [0:5];
  logic [1:0] m_err [2:4];
  bit         m_valid = 1'b0;

  function automatic logic [3:0] gray_of(input int b);
    return 4'(bin2gray(16'(b % 16)));
  endfunction

  // Inverse Gray by search, independent of the package decoder.
  function automatic logic [3:0] m_bin(input logic [3:0] g);
    for (int b = 0; b < 16; b++) begin
      if (gray_of(b) == g) return 4'(b);
    end
    return 4'(0);
  endfunction

  always @(posedge clk) begin
    if (rrst) begin
      for (int k = 0; k < 6; k++) hist[k] = '0;
      for (int s = 2; s <= 4; s++) m_err[s] = '0;
      m_valid = 1'b1;
    end else begin
      for (int s = 2; s <= 4; s++) begin
        logic [3:0] cnt;
        logic jump;
        cnt  = m_bin(hist[s]) - rptr_bin;
        jump = ($countones(hist[s-1] ^ hist[s]) > 1);
        m_err[s][0] = jump | (m_err[s][0] & !err_clr);
        m_err[s][1] = (cnt > 4'd8) | (m_err[s][1] & !err_clr);
      end
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = wptr;
    end
  end

  task automatic chk(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[S%0d] t=%0t: got %0h expected %0h", nm, s, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      for (int s = 2; s <= 4; s++) begin
        logic [3:0] cnt;
        cnt = m_bin(hist[s]) - rptr_bin;
        chk("gray", s, 32'(d_gray[s]), 32'(hist[s-1]));
        chk("bin", s, 32'(d_bin[s]), 32'(m_bin(hist[s])));
        chk("count", s, 32'(d_cnt[s]), 32'(cnt));
        chk("empty", s, 32'(d_empty[s]), 32'(cnt == 0));
        chk("aempty", s, 32'(d_ae[s]), 32'(cnt <= 2));
        chk("upd", s, 32'(d_upd[s]), 32'(hist[s] != hist[s+1]));
        chk("err", s, 32'(d_err[s]), 32'(m_err[s]));
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      upd_pulses += int'(d_upd[2]);
    end
  endtask

  initial begin
    step(2);
    rrst = 1'b0;
    chk("rst_count", 2, 32'(d_cnt[2]), 32'd0);
    chk("rst_empty", 2, 32'(d_empty[2]), 32'd1);
    chk("rst_ae", 2, 32'(d_ae[2]), 32'd1);
    chk("rst_err", 2, 32'(d_err[2]), 32'd0);

    // Single step 0 -> 1, latency per depth
    wptr = 4'b0001;
    step(2);
    chk("t1_gray", 2, 32'(d_gray[2]), 32'h1);
    chk("t1_bin_early", 2, 32'(d_bin[2]), 32'h0);
    step();
    chk("t1_bin", 2, 32'(d_bin[2]), 32'h1);
    chk("t1_upd", 2, 32'(d_upd[2]), 32'h1);
    chk("t1_count", 2, 32'(d_cnt[2]), 32'h1);
    chk("t1_empty", 2, 32'(d_empty[2]), 32'h0);
    chk("t1_ae", 2, 32'(d_ae[2]), 32'h1);
    chk("t1_bin_early", 3, 32'(d_bin[3]), 32'h0);
    step();
    chk("t1_upd_off", 2, 32'(d_upd[2]), 32'h0);
    chk("t1_bin", 3, 32'(d_bin[3]), 32'h1);
    chk("t1_bin_early", 4, 32'(d_bin[4]), 32'h0);
    step();
    chk("t1_bin", 4, 32'(d_bin[4]), 32'h1);

    // Walk to bin 8 (Gray 1100)
    upd_pulses = 0;
    for (int b = 2; b <= 8; b++) begin
      wptr = gray_of(b);
      step();
    end
    step(6);
    chk("t2_wptr_code", 2, 32'(wptr), 32'hC);
    chk("t2_pulses", 2, 32'(upd_pulses), 32'd7);
    chk("t2_count", 2, 32'(d_cnt[2]), 32'd8);
    chk("t2_ae", 2, 32'(d_ae[2]), 32'd0);
    chk("t2_err", 2, 32'(d_err[2]), 32'd0);
    chk("t2_err", 4, 32'(d_err[4]), 32'd0);

    // Wrap-around of the occupancy subtraction
    rptr_bin = 4'd8;
    for (int b = 9; b <= 15; b++) begin
      wptr = gray_of(b);
      step();
    end
    step(6);
    chk("t3_count_pre", 2, 32'(d_cnt[2]), 32'd7);
    rptr_bin = 4'b1110;
    step();
    for (int b = 16; b <= 17; b++) begin
      wptr = gray_of(b);
      step();
    end
    step(6);
    chk("t3_wptr_code", 2, 32'(wptr), 32'h1);
    chk("t3_count", 2, 32'(d_cnt[2]), 32'd3);
    rptr_bin = 4'b0001;
    #1;
    chk("t3_count0", 2, 32'(d_cnt[2]), 32'd0);
    chk("t3_empty", 2, 32'(d_empty[2]), 32'd1);
    chk("t3_err", 2, 32'(d_err[2]), 32'd0);

    // Multi-bit Gray jumps and clear priority
    wptr = '0;
    rptr_bin = '0;
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    wptr = 4'b0011;
    step(2);
    chk("t4_err_early", 2, 32'(d_err[2]), 32'd0);
    step();
    chk("t4_err_jump", 2, 32'(d_err[2]), 32'd1);
    wptr = 4'b0000;
    step(2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_clr_race", 2, 32'(d_err[2]), 32'd1);
    step(6);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    for (int s = 2; s <= 4; s++) chk("t4_err_cleared", s, 32'(d_err[s]), 32'd0);

    // Occupancy overflow (bin 9 against rptr 0)
    for (int b = 1; b <= 9; b++) begin
      wptr = gray_of(b);
      step();
    end
    step(6);
    chk("t5_wptr_code", 2, 32'(wptr), 32'hD);
    chk("t5_err_ovf", 2, 32'(d_err[2]), 32'd2);
    chk("t5_err_ovf", 4, 32'(d_err[4]), 32'd2);

    // Reset mid-transfer
    wptr = gray_of(10);
    step(2);
    rrst = 1'b1;
    step();
    for (int s = 2; s <= 4; s += 2) begin
      chk("t6_gray", s, 32'(d_gray[s]), 32'd0);
      chk("t6_bin", s, 32'(d_bin[s]), 32'd0);
      chk("t6_upd", s, 32'(d_upd[s]), 32'd0);
      chk("t6_err", s, 32'(d_err[s]), 32'd0);
      chk("t6_empty", s, 32'(d_empty[s]), 32'd1);
    end
    rrst = 1'b0;
    step(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptr_sync_rd_gen.md
Name: ptr_sync_rd_gen

Overview:
Parametrised read-domain receiver for the write pointer of an asynchronous FIFO. It replaces the fixed two-flop pointer synchroniser.
- Configurable synchroniser depth.
- Registered Gray-to-binary decode.
- Occupancy count, empty and almost-empty flags against the local read pointer.
- Update pulse, plus sticky integrity checks for multi-bit Gray jumps and impossible occupancy.
- Sits in the rclk domain between the write-pointer Gray register and the read-side control logic.

Parameters:
- ADDR_W, 8, FIFO address width; pointers are ADDR_W+1 bits (wrap bit included); legal range 2..15.
- STAGES, 2, number of synchroniser flops; legal range 2..4; out-of-range values are a fatal elaboration error.
- AE_LEVEL, 4, ralmost_empty asserts when rd_count <= AE_LEVEL; legal range 1..2^ADDR_W-1.

Ports:
- rclk, input, 1, read-domain clock; all flops on the rising edge.
- rrst, input, 1, reset; synchronous and active-high.
- wptr, input, ADDR_W+1, write pointer in Gray code, asynchronous to rclk.
- rptr_bin, input, ADDR_W+1, local binary read pointer, rclk domain.
- err_clr, input, 1, clears sync_err.
- rq_wptr_gray, output, ADDR_W+1, synchronised Gray pointer (last chain stage).
- rq_wptr_bin, output, ADDR_W+1, registered binary decode of rq_wptr_gray.
- rd_count, output, ADDR_W+1, entries available: (rq_wptr_bin - rptr_bin) mod 2^(ADDR_W+1).
- rempty, output, 1, rd_count == 0.
- ralmost_empty, output, 1, rd_count <= AE_LEVEL.
- wptr_upd, output, 1, one-cycle pulse when the decoded pointer changes.
- sync_err, output, 2, sticky flags: [0] multi-bit Gray jump, [1] occupancy overflow.

Behaviour:
- Clock and reset are fixed: one clock, rclk; rrst is synchronous and active-high.
- Reset (rrst=1 at the edge): all chain stages, rq_wptr_gray, rq_wptr_bin, the previous-sample register, wptr_upd and sync_err go to 0.
  - With rptr_bin=0 this gives rd_count=0, rempty=1, ralmost_empty=1.
  - A reset mid-operation discards in-flight samples; there is no partial flush.
- Chain: stage0 <= wptr, stage i <= stage i-1; rq_wptr_gray = stage STAGES-1.
  - A stable wptr change reaches rq_wptr_gray exactly STAGES cycles later.
- Decode stage (one cycle after rq_wptr_gray):
  - rq_wptr_bin <= gray2bin(rq_wptr_gray).
  - gprev <= rq_wptr_gray.
  - wptr_upd <= (rq_wptr_gray != gprev).
  - Total latency from wptr to rq_wptr_bin or wptr_upd is STAGES+1 cycles.
- Jump check: if popcount(rq_wptr_gray XOR gprev) > 1, set sync_err[0] on the decode edge; rq_wptr_bin still updates.
- Occupancy: rd_count, rempty and ralmost_empty are combinational from the rq_wptr_bin register and rptr_bin.
  - Zero latency to rptr_bin changes; no glitch-sensitive path crosses domains.
  - Subtraction is modulo 2^(ADDR_W+1); wrap-around is handled by that arithmetic.
- Overflow: rd_count > 2^ADDR_W sets sync_err[1] on the next edge. rd_count == 2^ADDR_W (full) is legal.
- sync_err is sticky until err_clr=1 at an edge.
  - A new error in the same cycle as err_clr wins: the bit stays or becomes 1.
  - rrst overrides everything.
- No handshake on wptr: the source guarantees at most one Gray bit changes per wclk, so the module only samples.

Decomposition:
- Shared package fifo_ptr_pkg:
  - gray2bin and bin2gray functions (bin2gray is for the bench and the write side).
  - STAGES_MIN=2 and STAGES_MAX=4 constants.
  - Error-bit index constants ERR_JUMP=0 and ERR_OVF=1.
- One sub-module, sync_chain_n (WIDTH, STAGES): the bare flop chain with synchronous active-high reset. It is reusable for the write-side mirror block.

Test Plan (ADDR_W=3, STAGES=2, AE_LEVEL=2 unless noted):
1. Reset, then wptr=0000 -> 0001 at edge k -> rq_wptr_gray=0001 after edge k+2; rq_wptr_bin=0001, rd_count=1, rempty=0, ralmost_empty=1 and one wptr_upd pulse after edge k+3.
2. Step wptr through the Gray sequence to 1100 (bin 8) with rptr_bin=0 -> rd_count=8, ralmost_empty=0, sync_err=00; wptr_upd pulses once per step.
3. Wrap: rptr_bin=1110 and wptr Gray 0001 -> rd_count=3 (mod 16); rptr_bin then steps to 0001 -> rd_count=0 and rempty=1 in the same cycle.
4. Error: wptr jumps 0000 -> 0011 -> sync_err[0]=1 at the decode edge. Apply err_clr while a second jump decodes -> bit stays 1. err_clr alone -> 00.
5. Overflow: rptr_bin=0 and wptr Gray 1101 (bin 9) -> sync_err[1]=1.
6. STAGES=4 and STAGES=3 regressions: latency to rq_wptr_bin is 5 and 4 cycles respectively. rrst asserted mid-transfer -> all outputs return to reset values on the next edge.
